// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data-memory responder sitting on the memory-stage interface of
// the pipelined MIPS core. One load or store is accepted at a time, serviced
// after LATENCY cycles in BUSY, and completed with a one-cycle resp_valid
// pulse. The pipeline is held with stall from the cycle the request is first
// seen until the access has been performed.
//
// Handshake (one rule for the whole block): the requester raises req_read or
// req_write and keeps req_* stable for as long as stall is high; the request
// completes in the single cycle where resp_valid=1 (stall=0 in that cycle),
// and the request still on the inputs during that cycle is not re-accepted.
//
// Parameters
//   WORDS      number of 32-bit words in the array (power of 2)
//   LATENCY    cycles spent in BUSY (1..15)
//   BASE_ADDR  byte address of word 0
//
// Ports
//   clk         clock, all state updates on rising edge
//   reset       synchronous, active-high
//   req_addr    byte address of request
//   req_wdata   store data
//   req_read    load request
//   req_write   store request
//   resp_rdata  load data, valid when resp_valid=1, held until next load
//   resp_valid  one-cycle completion pulse (load or store)
//   stall       pipeline must hold the request and freeze while high
//   err         one-cycle pulse together with resp_valid for a bad request
//   fsm_state   current FSM state (IDLE=0, BUSY=1, DONE=2) for observation
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          WORDS     = 1024,
    parameter int          LATENCY   = 3,
    parameter logic [31:0] BASE_ADDR = 32'h10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    output logic [31:0] resp_rdata,
    output logic        resp_valid,
    output logic        stall,
    output logic        err,
    output logic [1:0]  fsm_state
);

    localparam int          IDX_W    = $clog2(WORDS);
    // Size of the mapped window in bytes; 33 bits so 4*WORDS never overflows.
    localparam logic [32:0] SPAN     = 33'(WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] mem [WORDS];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             bad;

    // Unsigned 32-bit distance from the window base. Below-base addresses wrap
    // to large values, so they are caught separately by the addr < BASE check.
    assign offset = addr_q - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];

    // Classification is done on the latched request, never on live inputs.
    assign bad = (read_q & write_q)
               | (addr_q[1:0] != 2'b00)
               | (addr_q < BASE_ADDR)
               | ({1'b0, offset} >= SPAN);

    assign fsm_state = state;

    // In IDLE the stall must rise in the same cycle the request appears so the
    // pipeline freezes before the next edge.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_read | req_write;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            resp_rdata <= 32'd0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read | req_write) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        read_q  <= req_read;
                        write_q <= req_write;
                        count   <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        if (!bad) begin
                            if (write_q) begin
                                mem[idx] <= wdata_q;
                            end else begin
                                resp_rdata <= mem[idx];
                            end
                        end else if (read_q) begin
                            // A rejected load still completes, returning zero.
                            resp_rdata <= 32'd0;
                        end
                        resp_valid <= 1'b1;
                        err        <= bad;
                        state      <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    // Request still present here is the one just served.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
